// File: rtl/spi_master_param_if.sv
// Bus between the local controller, the SPI master and the slaves.
// The bus carries the request, the latched-mode inputs, the serial lines and the status.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              ENABLE;
    logic              CKP;
    logic              CPH;
    logic [CS_W-1:0]   CS_SEL;
    logic [DATA_W-1:0] DATAINPUT;
    logic              MISO;
    logic              MOSI;
    logic              SCK;
    logic [NUM_CS-1:0] CS;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] DATAOUT;

    modport master (
        input  ENABLE, CKP, CPH, CS_SEL, DATAINPUT, MISO,
        output MOSI, SCK, CS, BUSY, DONE, DATAOUT
    );

    modport slave (
        output ENABLE, CKP, CPH, CS_SEL, DATAINPUT, MISO,
        input  MOSI, SCK, CS, BUSY, DONE, DATAOUT
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with the four CKP/CPH modes, DIV-cycle SCK half-periods,
// NUM_CS active-low selects, a BUSY/DONE handshake and capture of the received word.
//
// state   | meaning
// S_IDLE  | CS all high, SCK follows CKP, waiting for ENABLE with a valid CS_SEL
// S_SETUP | CS low, waiting DIV cycles before the first SCK edge
// S_XFER  | generating SCK edges 2..2*DATA_W, shifting MOSI out and MISO in
// S_HOLD  | SCK at rest, CS and MOSI held DIV cycles, then DONE
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 2,
    parameter int NUM_CS    = 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                CLK,
    input  logic                RESET,
    spi_master_param_if.master  bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [EDGE_W-1:0] EDGES_ALL  = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(1);
    localparam logic [CS_W:0]     NUM_CS_L   = (CS_W + 1)'(NUM_CS);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [EDGE_W-1:0] edges_left_q, edges_left_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ckp_q, ckp_d;
    logic              cph_q, cph_d;
    logic [CS_W-1:0]   sel_q, sel_d;
    logic              mosi_q, mosi_d;
    logic              sck_q, sck_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic              tick;
    logic              leading;
    logic              sel_ok;

    function automatic logic out_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign sel_ok  = ({1'b0, bus.CS_SEL} < NUM_CS_L);
    assign tick    = (div_cnt_q == '0);
    // 2*DATA_W is even, so an even count of remaining edges means the next edge is a leading one.
    assign leading = ~edges_left_q[0];

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        edges_left_d = edges_left_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        dout_d       = dout_q;
        ckp_d        = ckp_q;
        cph_d        = cph_q;
        sel_d        = sel_q;
        mosi_d       = mosi_q;
        sck_d        = sck_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cs_d         = cs_q;

        if (state_q != S_IDLE) begin
            div_cnt_d = tick ? DIV_RELOAD : div_cnt_q - 1'b1;
            cs_d      = ~(NUM_CS'(1) << sel_q);
        end

        case (state_q)
            S_IDLE: begin
                sck_d = bus.CKP;
                if (bus.ENABLE && sel_ok) begin
                    state_d      = S_SETUP;
                    ckp_d        = bus.CKP;
                    cph_d        = bus.CPH;
                    sel_d        = bus.CS_SEL;
                    busy_d       = 1'b1;
                    cs_d         = ~(NUM_CS'(1) << bus.CS_SEL);
                    div_cnt_d    = DIV_RELOAD;
                    edges_left_d = EDGES_ALL;
                    rx_d         = '0;
                    if (!bus.CPH) begin
                        mosi_d = out_bit(bus.DATAINPUT);
                        tx_d   = shift_out(bus.DATAINPUT);
                    end else begin
                        mosi_d = 1'b0;
                        tx_d   = bus.DATAINPUT;
                    end
                end
            end
            S_SETUP, S_XFER: begin
                if (tick) begin
                    state_d      = (edges_left_q == EDGE_LAST) ? S_HOLD : S_XFER;
                    sck_d        = ~sck_q;
                    edges_left_d = edges_left_q - 1'b1;
                    if (leading != cph_q) begin
                        rx_d = LSB_FIRST ? {bus.MISO, rx_q[DATA_W-1:1]}
                                         : {rx_q[DATA_W-2:0], bus.MISO};
                    end else if (cph_q || (edges_left_q != EDGE_LAST)) begin
                        mosi_d = out_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end
                end
            end
            S_HOLD: begin
                sck_d = ckp_q;
                if (tick) begin
                    state_d = S_IDLE;
                    cs_d    = '1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            edges_left_q <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            dout_q       <= '0;
            ckp_q        <= 1'b0;
            cph_q        <= 1'b0;
            sel_q        <= '0;
            mosi_q       <= 1'b0;
            sck_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cs_q         <= '1;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            edges_left_q <= edges_left_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            dout_q       <= dout_d;
            ckp_q        <= ckp_d;
            cph_q        <= cph_d;
            sel_q        <= sel_d;
            mosi_q       <= mosi_d;
            sck_q        <= sck_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cs_q         <= cs_d;
        end
    end

    assign bus.MOSI    = mosi_q;
    assign bus.SCK     = sck_q;
    assign bus.CS      = cs_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.DATAOUT = dout_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: default instance against a mode-aware SPI slave model,
// plus a 16-bit/LSB-first/4-select instance and a 3-select instance for select handling.
module tb_spi_master_param;
    localparam int W0 = 8;
    localparam int DIV0 = 2;
    localparam int LAT0 = DIV0 * (2 * W0 + 1);
    localparam int LAT1 = 1 * (2 * 16 + 1);

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    spi_master_param_if #(.DATA_W(8),  .NUM_CS(1)) b0 ();
    spi_master_param_if #(.DATA_W(16), .NUM_CS(4)) b1 ();
    spi_master_param_if #(.DATA_W(8),  .NUM_CS(3)) b2 ();

    spi_master_param #(.DATA_W(8), .DIV(2), .NUM_CS(1), .LSB_FIRST(1'b0))
        dut0 (.CLK(CLK), .RESET(RESET), .bus(b0));
    spi_master_param #(.DATA_W(16), .DIV(1), .NUM_CS(4), .LSB_FIRST(1'b1))
        dut1 (.CLK(CLK), .RESET(RESET), .bus(b1));
    spi_master_param #(.DATA_W(8), .DIV(2), .NUM_CS(3), .LSB_FIRST(1'b0))
        dut2 (.CLK(CLK), .RESET(RESET), .bus(b2));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave for dut0: MSB-first, mode taken from what the bench requested, not from the DUT.
    logic       loop0 = 1'b0;
    logic       cur_cph = 1'b0;
    logic [7:0] s_tx = '0;
    logic [7:0] s_rx = '0;
    logic       s_miso = 1'b0;
    logic       s_prev_sck = 1'b0;
    logic       s_active = 1'b0;
    int         s_edges = 0;
    int         s_idx = 0;

    assign b0.MISO = loop0 ? b0.MOSI : s_miso;
    assign b1.MISO = b1.MOSI;
    assign b2.MISO = b2.MOSI;

    always @(negedge CLK) begin
        if (b0.CS !== 1'b0) begin
            s_active   = 1'b0;
            s_prev_sck = b0.SCK;
        end else begin
            if (!s_active) begin
                s_active = 1'b1;
                s_edges  = 0;
                s_rx     = '0;
                s_idx    = 7;
                if (!cur_cph) begin
                    s_miso = s_tx[7];
                    s_idx  = 6;
                end
            end
            if (b0.SCK !== s_prev_sck) begin
                s_edges++;
                if (((s_edges % 2) == 1) != cur_cph) s_rx = {s_rx[6:0], b0.MOSI};
                else if (s_idx >= 0) begin
                    s_miso = s_tx[s_idx];
                    s_idx--;
                end
            end
            s_prev_sck = b0.SCK;
        end
    end

    typedef struct {
        logic       ckp;
        logic       cph;
        logic [7:0] din;
        logic [7:0] sw;
        logic       loop;
        int         poke;
        logic [7:0] exp_out;
        logic [7:0] exp_rx;
    } vec_t;

    // A full-duplex exchange: master ends with the slave's word (or its own when looped back),
    // the slave ends with the master's word.
    function automatic logic [15:0] ref_xfer(input logic [7:0] din, input logic [7:0] sw, input logic loop);
        return {(loop ? din : sw), din};
    endfunction

    task automatic xfer0(input vec_t v, input string tag);
        int lat;
        int bad;
        @(negedge CLK);
        b0.CKP = v.ckp; b0.CPH = v.cph; b0.DATAINPUT = v.din; b0.CS_SEL = 1'b0;
        loop0 = v.loop; cur_cph = v.cph; s_tx = v.sw;
        repeat (2) @(negedge CLK);
        chk($sformatf("%s sck_idle", tag), b0.SCK, v.ckp);
        b0.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b0.ENABLE = 1'b0;
        chk($sformatf("%s cs_edge0", tag), b0.CS, 0);
        lat = 0;
        bad = 0;
        while (b0.DONE !== 1'b1 && lat < 200) begin
            if (b0.CS !== 1'b0 || b0.BUSY !== 1'b1) bad++;
            b0.ENABLE = (lat + 1 == v.poke);
            if (lat + 1 == v.poke) b0.DATAINPUT = 8'hFF;
            @(posedge CLK); #1;
            lat++;
            if (lat == 5) begin
                b0.CKP = 1'($urandom); b0.CPH = 1'($urandom);
                b0.CS_SEL = 1'($urandom); b0.DATAINPUT = 8'($urandom);
            end
        end
        b0.ENABLE = 1'b0;
        chk($sformatf("%s latency", tag), lat, LAT0);
        chk($sformatf("%s cs_busy_during", tag), bad, 0);
        chk($sformatf("%s cs_at_done", tag), b0.CS, 1);
        chk($sformatf("%s busy_at_done", tag), b0.BUSY, 0);
        chk($sformatf("%s mosi_at_done", tag), b0.MOSI, 0);
        chk($sformatf("%s sck_rest", tag), b0.SCK, v.ckp);
        chk($sformatf("%s dataout", tag), b0.DATAOUT, v.exp_out);
        chk($sformatf("%s slave_rx", tag), s_rx, v.exp_rx);
        chk($sformatf("%s sck_edges", tag), s_edges, 2 * W0);
        @(posedge CLK); #1;
        chk($sformatf("%s done_width", tag), b0.DONE, 0);
        chk($sformatf("%s no_restart", tag), b0.BUSY, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int lat;
        int bad;
        int nb;
        int seen;
        logic prev;
        logic [15:0] word;

        tbl[0] = '{1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, -1, 8'hA5, 8'hA5};
        tbl[1] = '{1'b0, 1'b0, 8'hC3, 8'h3C, 1'b0, -1, 8'h3C, 8'hC3};
        tbl[2] = '{1'b0, 1'b1, 8'hC3, 8'h3C, 1'b0, -1, 8'h3C, 8'hC3};
        tbl[3] = '{1'b1, 1'b0, 8'hC3, 8'h3C, 1'b0, -1, 8'h3C, 8'hC3};
        tbl[4] = '{1'b1, 1'b1, 8'hC3, 8'h3C, 1'b0, -1, 8'h3C, 8'hC3};
        tbl[5] = '{1'b0, 1'b0, 8'h12, 8'h5A, 1'b0, 10, 8'h5A, 8'h12};
        tbl[6] = '{1'b1, 1'b1, 8'h81, 8'h7E, 1'b0, LAT0, 8'h7E, 8'h81};

        RESET = 1'b0;
        b0.ENABLE = 1'b0; b0.CKP = 1'b0; b0.CPH = 1'b0; b0.CS_SEL = '0; b0.DATAINPUT = '0;
        b1.ENABLE = 1'b0; b1.CKP = 1'b0; b1.CPH = 1'b0; b1.CS_SEL = '0; b1.DATAINPUT = '0;
        b2.ENABLE = 1'b0; b2.CKP = 1'b0; b2.CPH = 1'b0; b2.CS_SEL = '0; b2.DATAINPUT = '0;
        repeat (3) @(posedge CLK); #1;
        chk("rst mosi", b0.MOSI, 0);
        chk("rst sck", b0.SCK, 0);
        chk("rst cs", b0.CS, 1);
        chk("rst busy", b0.BUSY, 0);
        chk("rst done", b0.DONE, 0);
        chk("rst dataout", b0.DATAOUT, 0);
        chk("rst cs4", b1.CS, 4'hF);
        @(negedge CLK);
        RESET = 1'b1;

        // Reset in the middle of a CKP=1 transfer of 8'hFF.
        b0.CKP = 1'b1; b0.CPH = 1'b0; b0.DATAINPUT = 8'hFF; cur_cph = 1'b0; s_tx = '0;
        repeat (3) @(negedge CLK);
        b0.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b0.ENABLE = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        chk("abort mosi_before", b0.MOSI, 1);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("abort cs", b0.CS, 1);
        chk("abort sck", b0.SCK, 0);
        chk("abort mosi", b0.MOSI, 0);
        chk("abort busy", b0.BUSY, 0);
        chk("abort dataout", b0.DATAOUT, 0);
        RESET = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (b0.DONE === 1'b1) seen++;
        end
        chk("abort no_done", seen, 0);

        for (int i = 0; i < 7; i++) xfer0(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.ckp  = 1'($urandom);
            v.cph  = 1'($urandom);
            v.din  = 8'($urandom);
            v.sw   = 8'($urandom);
            v.loop = ($urandom_range(3, 0) == 0);
            v.poke = ($urandom_range(2, 0) == 0) ? int'($urandom_range(LAT0, 1)) : -1;
            {v.exp_out, v.exp_rx} = ref_xfer(v.din, v.sw, v.loop);
            xfer0(v, $sformatf("rnd%0d", i));
        end

        // dut0 has one select: CS_SEL=1 is out of range.
        @(negedge CLK);
        b0.CS_SEL = 1'b1;
        b0.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b0.ENABLE = 1'b0;
        chk("sel_oob1 busy", b0.BUSY, 0);
        chk("sel_oob1 cs", b0.CS, 1);

        // 16-bit, DIV=1, LSB first, select 2, looped back.
        @(negedge CLK);
        b1.CKP = 1'b0; b1.CPH = 1'b0; b1.CS_SEL = 2'd2; b1.DATAINPUT = 16'h1234;
        repeat (2) @(negedge CLK);
        b1.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b1.ENABLE = 1'b0;
        chk("w16 cs_edge0", b1.CS, 4'b1011);
        chk("w16 busy", b1.BUSY, 1);
        lat = 0; bad = 0; nb = 0; word = '0; prev = b1.SCK;
        while (b1.DONE !== 1'b1 && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
            if (b1.DONE !== 1'b1 && b1.CS !== 4'b1011) bad++;
            if (b1.SCK === 1'b1 && prev === 1'b0) begin
                if (nb < 16) word[nb] = b1.MOSI;
                nb++;
            end
            prev = b1.SCK;
        end
        chk("w16 latency", lat, LAT1);
        chk("w16 cs_only2", bad, 0);
        chk("w16 rising_edges", nb, 16);
        chk("w16 mosi_order", word, 16'h1234);
        chk("w16 dataout", b1.DATAOUT, 16'h1234);
        chk("w16 cs_after", b1.CS, 4'hF);

        // Select 0 on the 4-select instance.
        @(negedge CLK);
        b1.CS_SEL = 2'd0; b1.DATAINPUT = 16'hBEEF;
        b1.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b1.ENABLE = 1'b0;
        chk("sel0 cs", b1.CS, 4'b1110);
        lat = 0;
        while (b1.DONE !== 1'b1 && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("sel0 latency", lat, LAT1);
        chk("sel0 dataout", b1.DATAOUT, 16'hBEEF);

        // Three selects: index 3 is rejected, index 2 is used.
        @(negedge CLK);
        b2.CS_SEL = 2'd3; b2.DATAINPUT = 8'h6B;
        b2.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b2.ENABLE = 1'b0;
        chk("sel_oob3 busy", b2.BUSY, 0);
        chk("sel_oob3 cs", b2.CS, 3'b111);
        seen = 0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (b2.BUSY === 1'b1 || b2.DONE === 1'b1) seen++;
        end
        chk("sel_oob3 quiet", seen, 0);
        @(negedge CLK);
        b2.CS_SEL = 2'd2;
        b2.ENABLE = 1'b1;
        @(posedge CLK); #1;
        b2.ENABLE = 1'b0;
        chk("sel2 cs", b2.CS, 3'b011);
        lat = 0;
        while (b2.DONE !== 1'b1 && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("sel2 latency", lat, LAT0);
        chk("sel2 dataout", b2.DATAOUT, 8'h6B);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
